if_fetch_ctrl: RTL and testbench

//  Instruction fetch controller between the instruction ROM and the core decode stage.

---
 rtl/if_fetch_ctrl_if.sv | 42 ++++
 rtl/if_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bundle: instruction ROM port, core handshake, redirect and halt status.
// master = fetch controller, slave = ROM/core environment.
interface if_fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_instr;
   logic              fetch_en;
   logic              inst_valid;
   logic [31:0]       inst_data;
   logic [31:0]       inst_pc;
   logic              inst_ready;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              halted;

   modport master (
      output im_addr,
      input  im_instr,
      input  fetch_en,
      output inst_valid,
      output inst_data,
      output inst_pc,
      input  inst_ready,
      input  redirect,
      input  redirect_pc,
      output halted
   );

   modport slave (
      input  im_addr,
      output im_instr,
      output fetch_en,
      input  inst_valid,
      input  inst_data,
      input  inst_pc,
      output inst_ready,
      output redirect,
      output redirect_pc,
      input  halted
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: owns fetch PC, prefetches ROM words into a FIFO, handles redirects.
// Optional macro IFC_ECALL_HALT_EN: an ecall push halts fetching until the next redirect.
module if_fetch_ctrl #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst_n,
   if_fetch_ctrl_if.master bus
);

   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef IFC_ECALL_HALT_EN
   localparam logic [31:0] ECALL = 32'h0000_0073;
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;
`else
   typedef enum logic [1:0] {ST_BOOT, ST_RUN} state_t;
`endif

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc_mem    [DEPTH];

   logic valid;
   logic pop;
   logic push;

   assign valid = (count_q != '0);
   // A redirect voids any handshake in its own cycle, so it gates both pop and push.
   assign pop   = valid & bus.inst_ready & ~bus.redirect;
   assign push  = (state_q == ST_RUN) & bus.fetch_en & ~bus.redirect
                  & ((count_q < DEPTH_C) | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (bus.redirect) begin
         // Every state lands in RUN after a redirect; BOOT's single cycle is still spent.
         state_d    = ST_RUN;
         fetch_pc_d = bus.redirect_pc & ~32'h3;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
`ifdef IFC_ECALL_HALT_EN
            ST_RUN:  if (push && bus.im_instr == ECALL) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
`else
            ST_RUN:  state_d = ST_RUN;
`endif
            default: state_d = ST_BOOT;
         endcase

         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   // Payload storage carries no reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= bus.im_instr;
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   assign bus.im_addr    = fetch_pc_q[ADDR_W+1:2];
   assign bus.inst_valid = valid;
   assign bus.inst_data  = instr_mem[rd_ptr_q];
   assign bus.inst_pc    = pc_mem[rd_ptr_q];

`ifdef IFC_ECALL_HALT_EN
   assign bus.halted = (state_q == ST_HALT);
`else
   assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_if_fetch_ctrl;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rom [64];

   if_fetch_ctrl_if #(.ADDR_W(16)) bus ();

   if_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(16), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.im_instr = rom[bus.im_addr[5:0]];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_boot;
   bit          m_halt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'h0;
      m_boot = 1'b1;
      m_halt = 1'b0;
   endtask

   // One clock edge of the fetch rules, expressed on the model queue.
   task automatic model_edge(input bit rdy, input bit fen, input bit rd, input logic [31:0] rpc);
      bit          popped;
      bit          pushed;
      logic [31:0] w;
      if (rd) begin
         mq.delete();
         m_pc   = rpc & ~32'h3;
         m_boot = 1'b0;
         m_halt = 1'b0;
      end else begin
         popped = (mq.size() != 0) && rdy;
         pushed = !m_boot && !m_halt && fen && ((mq.size() < DEPTH) || popped);
         w      = rom[m_pc[7:2]];
         if (popped) void'(mq.pop_front());
         if (pushed) begin
            mq.push_back('{pc: m_pc, instr: w});
`ifdef IFC_ECALL_HALT_EN
            if (w == 32'h0000_0073) m_halt = 1'b1;
`endif
            m_pc = m_pc + 32'd4;
         end
         m_boot = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, mq.size() != 0});
      chk("im_addr", {16'b0, bus.im_addr}, {16'b0, m_pc[17:2]});
      chk("halted", {31'b0, bus.halted}, {31'b0, m_halt});
      if (mq.size() != 0) begin
         chk("inst_pc", bus.inst_pc, mq[0].pc);
         chk("inst_data", bus.inst_data, mq[0].instr);
      end
   endtask

   // Called just after a falling edge: drive, advance model over the rising edge, check.
   task automatic step(input bit rdy, input bit fen, input bit rd, input logic [31:0] rpc);
      bus.inst_ready  = rdy;
      bus.fetch_en    = fen;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      model_edge(rdy, fen, rd, rpc);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h0000_1000;
      rom[0] = 32'h0000_0293;
      rom[1] = 32'h0000_0393;

      rst_n           = 1'b0;
      bus.fetch_en    = 1'b0;
      bus.inst_ready  = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rst_im_addr", {16'b0, bus.im_addr}, 32'd0);
      chk("rst_halted", {31'b0, bus.halted}, 32'd0);
      rst_n = 1'b1;

      // Reset and fill
      step(0, 1, 0, 0);
      chk("boot_no_push", {31'b0, bus.inst_valid}, 32'd0);
      step(0, 1, 0, 0);
      chk("first_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("first_pc", bus.inst_pc, 32'h0);
      chk("first_data", bus.inst_data, 32'h0000_0293);
      repeat (4) step(0, 1, 0, 0);
      chk("full_im_addr", {16'b0, bus.im_addr}, 32'd4);
      repeat (3) step(0, 0, 0, 0);

      // Streaming with full FIFO
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 0);
         chk("stream_pc", bus.inst_pc, 32'(4 * (i + 1)));
      end

      // Redirect with FIFO holding pc 0..12
      step(0, 1, 1, 32'h0);
      repeat (4) step(0, 1, 0, 0);
      chk("pre_redir_head", bus.inst_pc, 32'h0);
      step(0, 1, 1, 32'h34);
      chk("redir_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("redir_im_addr", {16'b0, bus.im_addr}, 32'd13);
      step(0, 1, 0, 0);
      chk("redir_pc", bus.inst_pc, 32'h34);

      // Redirect together with ready
      repeat (4) step(0, 1, 0, 0);
      step(1, 1, 1, 32'h80);
      chk("redir_rdy_valid", {31'b0, bus.inst_valid}, 32'd0);
      repeat (6) step(1, 1, 0, 0);

      // Misaligned target and 32-bit wrap
      step(1, 1, 1, 32'hFFFF_FFFE);
      chk("wrap_im_addr", {16'b0, bus.im_addr}, 32'h0000_FFFF);
      step(1, 1, 0, 0);
      chk("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
      chk("wrap_im_addr0", {16'b0, bus.im_addr}, 32'd0);
      step(1, 1, 0, 0);
      chk("wrap_pc0", bus.inst_pc, 32'h0);

`ifdef IFC_ECALL_HALT_EN
      rom[2] = 32'h0000_0073;
      step(0, 1, 1, 32'h0);
      repeat (6) step(0, 1, 0, 0);
      chk("ecall_halted", {31'b0, bus.halted}, 32'd1);
      repeat (3) step(1, 1, 0, 0);
      chk("ecall_drained", {31'b0, bus.inst_valid}, 32'd0);
      step(0, 1, 1, 32'h0);
      chk("ecall_unhalt", {31'b0, bus.halted}, 32'd0);
      step(0, 1, 0, 0);
      chk("ecall_refetch", bus.inst_pc, 32'h0);
`endif

      // Stable hold: full, no ready, fetch disabled
      repeat (5) step(0, 1, 0, 0);
      repeat (4) step(0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 19) == 0, $urandom);
      end

      // Reset mid-operation discards the FIFO
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
